// File: rtl/cs_resolve_acc.sv
// Carry-save row resolver and frame accumulator: resolves sum/carry pairs to
// binary, sums them across a frame and returns one total per frame.
module cs_resolve_acc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [7:0]       out_beats
);

    localparam int unsigned VAL_W = WIDTH + 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The resolved row must fit in the accumulator without truncation.
    generate
        if (ACC_W < WIDTH + 2) begin : g_bad_acc_w
            $error("cs_resolve_acc: ACC_W must be at least WIDTH+2");
        end
    endgenerate

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    out_state_e         state;
    out_state_e         state_nxt;

    logic               s1_v;
    logic               s1_last;
    logic [VAL_W-1:0]   s1_val;

    logic [ACC_W-1:0]   acc;
    logic               acc_ovf;
    logic [CNT_W-1:0]   acc_cnt;

    logic               consume_c;
    logic               accept_c;
    logic               load_out_c;
    logic [ACC_W:0]     sum_ext_c;
    logic               carry_c;
    logic [CNT_W-1:0]   cnt_inc_c;

    // Handshake: only a last beat facing a held, untaken result stalls.
    always_comb begin
        consume_c = s1_v && !(s1_last && out_valid && !out_ready);
        in_ready  = !s1_v || consume_c;
        accept_c  = in_valid && in_ready;
    end

    // Accumulator adder with carry-out and saturating beat count.
    always_comb begin
        sum_ext_c = {1'b0, acc} + (ACC_W + 1)'(s1_val);
        carry_c   = sum_ext_c[ACC_W];
        cnt_inc_c = (acc_cnt == CNT_MAX) ? CNT_MAX : acc_cnt + CNT_W'(1);
    end

    // Stage 1: final carry-propagate add of the redundant pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_val  <= '0;
        end else if (accept_c) begin
            s1_v    <= 1'b1;
            s1_last <= in_last;
            s1_val  <= VAL_W'(in_sum) + (VAL_W'(in_carry) << 1);
        end else if (consume_c) begin
            s1_v    <= 1'b0;
        end
    end

    // Stage 2: frame accumulator, cleared when the frame's last beat leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
            acc_cnt <= '0;
        end else if (consume_c) begin
            if (s1_last) begin
                acc     <= '0;
                acc_ovf <= 1'b0;
                acc_cnt <= '0;
            end else begin
                acc     <= sum_ext_c[ACC_W-1:0];
                acc_ovf <= acc_ovf | carry_c;
                acc_cnt <= cnt_inc_c;
            end
        end
    end

    // Output FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Output FSM next state; a new result may replace one taken on this edge.
    always_comb begin
        state_nxt  = state;
        load_out_c = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (consume_c && s1_last) begin
                    load_out_c = 1'b1;
                    state_nxt  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (consume_c && s1_last) begin
                    load_out_c = 1'b1;
                    state_nxt  = ST_FULL;
                end else if (out_ready) begin
                    state_nxt  = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    assign out_valid = (state == ST_FULL);

    // Result registers hold steady until a new frame total is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
        end else if (load_out_c) begin
            out_data  <= sum_ext_c[ACC_W-1:0];
            out_ovf   <= acc_ovf | carry_c;
            out_beats <= cnt_inc_c;
        end
    end

endmodule
